// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration master: frame geometry,
// peripheral register map, FSM state encoding and small helper functions.
package spi_cfg_pkg;

  localparam int FRAME_BITS = 16;

  // Register map of the SPI register peripheral
  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'd0;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'd1;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'd2;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'd3;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Width of a requester index; a single requester still needs one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Write frame, sent LSB first: write flag, address, then data
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [6:0] addr,
                                                        input logic [7:0] data);
    return {data, addr, 1'b1};
  endfunction

endpackage

// File: rtl/spi_cfg_master_rr_arbiter.sv
// Round-robin arbiter: grants the lowest pending index at or after the
// pointer (wrapping), and moves the pointer past the winner on accept.
module rr_arbiter
  import spi_cfg_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  localparam logic [IDX_W:0]   N_W  = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   ptr_q;
  logic [NUM_REQ-1:0] req_rot;
  logic [IDX_W-1:0]   off;
  logic               found;
  logic [IDX_W:0]     sum;

  // Rotate requests so the pointer position lands at bit 0
  assign req_rot = NUM_REQ'({req, req} >> ptr_q);

  // Find first pending request after rotation and map it back to an index
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found = 1'b1;
        off   = IDX_W'(i);
      end
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= N_W) sum = sum - N_W;
    grant_idx = sum[IDX_W-1:0];
    grant_vld = found && enable;
    grant     = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  // Pointer moves just past the accepted requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (accept && grant_vld) begin
      ptr_q <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/spi_cfg_master.sv
// Arbitrated SPI mode-0 write master for the SPI register peripheral.
// Optional macro SPI_CFG_ADDR_CHECK_EN: grants carrying an address above
// MAX_ADDR are acknowledged with err instead of being framed.
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int IDLE_GAP = 4,
  parameter int MAX_ADDR = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 sclk,
  output logic                 copi,
  output logic                 ncs
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, IDLE_GAP) + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_GAP - 1);
  localparam logic [4:0]       LAST_BIT   = 5'(FRAME_BITS - 1);
  localparam logic [6:0]       MAX_ADDR_C = 7'(MAX_ADDR);

`ifdef SPI_CFG_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4:0]              bit_q, bit_d;
  logic [FRAME_BITS-1:0]   sh_q, sh_d;
  logic                    sclk_q, sclk_d, copi_q, copi_d, ncs_q, ncs_d;
  logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [NUM_REQ-1:0]      ready_q, ready_d;
  logic                    accept, arb_en, gnt_vld;
  logic [NUM_REQ-1:0]      gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic [6:0]              sel_addr;
  logic [7:0]              sel_data;

  // No grant in the cycle req_ready is shown: the winner still holds valid then
  assign arb_en = (state_q == ST_IDLE) && (ready_q == '0);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .enable    (arb_en),
    .accept    (accept),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_vld (gnt_vld)
  );

  // Select address/data of the granted requester
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel_addr = req_addr[7*i +: 7];
        sel_data = req_data[8*i +: 8];
      end
    end
  end

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    ncs_d   = ncs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ready_d = '0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          ready_d = gnt;
          accept  = 1'b1;
          if (ADDR_CHECK && (sel_addr > MAX_ADDR_C)) begin
            err_d = 1'b1;
          end else begin
            sh_d    = build_frame(sel_addr, sel_data);
            state_d = ST_SETUP;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        ncs_d  = 1'b0;
        copi_d = sh_q[0];
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (sclk_q) begin
            // Falling edge: the only place copi may advance
            sclk_d = 1'b0;
            copi_d = sh_q[1];
            sh_d   = sh_q >> 1;
          end else if (bit_q == LAST_BIT) begin
            state_d = ST_HOLD;
          end else begin
            bit_d  = bit_q + 1'b1;
            sclk_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          copi_d  = 1'b0;
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      ncs_q   <= ncs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  // Frame shift register is pure data and needs no reset
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign sclk      = sclk_q;
  assign copi      = copi_q;
  assign ncs       = ncs_q;

endmodule
